// File: rtl/imm_gen_pkg.sv
// Shared decode definitions for the immediate generator: opcodes, format codes
// and the decode-result record.
package imm_gen_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_e;

  // Widest legal immediate; narrower builds keep the low XLEN bits.
  typedef struct packed {
    logic [63:0] imm;
    imm_fmt_e    fmt;
    logic        err;
  } dec_res_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Decode-stage bus: instruction valid/ready in, immediate valid/ready out, flush.
interface imm_gen_pipe_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm;
  logic [2:0]      imm_fmt;
  logic            imm_err;
  logic            flush;

  modport slave (
    input  in_valid, inst, out_ready, flush,
    output in_ready, out_valid, imm, imm_fmt, imm_err
  );

  modport master (
    output in_valid, inst, out_ready, flush,
    input  in_ready, out_valid, imm, imm_fmt, imm_err
  );
endinterface

// File: rtl/imm_decode_comb.sv
// Pure combinational instruction -> {immediate, format, error} decoder.
module imm_decode_comb
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_e        fmt_o,
  output logic            err_o
);

  logic s;
  assign s = inst_i[31];

  always_comb begin
    imm_o = '0;
    fmt_o = FMT_NONE;
    err_o = 1'b0;
    case (inst_i[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_IMM32: begin
        imm_o = {{(XLEN-12){s}}, inst_i[31:20]};
        fmt_o = FMT_I;
      end
      OP_STORE: begin
        imm_o = {{(XLEN-12){s}}, inst_i[31:25], inst_i[11:7]};
        fmt_o = FMT_S;
      end
      OP_BRANCH: begin
        imm_o = {{(XLEN-12){s}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        fmt_o = FMT_B;
      end
      OP_JAL: begin
        imm_o = {{(XLEN-20){s}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
        fmt_o = FMT_J;
      end
      OP_LUI, OP_AUIPC: begin
        imm_o = XLEN'($signed({inst_i[31:12], 12'b0}));
        fmt_o = FMT_U;
      end
      OP_SYSTEM: begin
        // Only the immediate CSR forms carry a (zero-extended) uimm.
        if (inst_i[14]) begin
          imm_o = XLEN'(inst_i[19:15]);
          fmt_o = FMT_Z;
        end
      end
      OP_REG, OP_FENCE: ;
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a DEPTH-entry output FIFO and flush.
// Optional IMM_GEN_PIPE_STATS_EN adds push and error counters.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  imm_gen_pipe_if.slave bus
`ifdef IMM_GEN_PIPE_STATS_EN
  ,
  output logic [31:0]   stat_decoded,
  output logic [15:0]   stat_err
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    logic            err;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_err;
  logic            full, empty, push, pop;

  imm_decode_comb #(.XLEN(XLEN)) u_dec (
    .inst_i (bus.inst),
    .imm_o  (dec_imm),
    .fmt_o  (dec_fmt),
    .err_o  (dec_err)
  );

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  // Full blocks input even when the head is popping this cycle.
  assign push  = bus.in_valid && !full && !bus.flush;
  assign pop   = bus.out_ready && !empty && !bus.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= '{imm: dec_imm, fmt: dec_fmt, err: dec_err};
    end
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.imm       = mem_q[rd_ptr_q].imm;
  assign bus.imm_fmt   = mem_q[rd_ptr_q].fmt;
  assign bus.imm_err   = mem_q[rd_ptr_q].err;

`ifdef IMM_GEN_PIPE_STATS_EN
  logic [31:0] stat_decoded_q;
  logic [15:0] stat_err_q;

  // Flush leaves the counters alone; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_decoded_q <= '0;
      stat_err_q     <= '0;
    end else if (push) begin
      stat_decoded_q <= stat_decoded_q + 32'd1;
      if (dec_err && stat_err_q != 16'hFFFF) stat_err_q <= stat_err_q + 16'd1;
    end
  end

  assign stat_decoded = stat_decoded_q;
  assign stat_err     = stat_err_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus
// stream and are checked every cycle against a queue-based reference model.
module tb_imm_gen_pipe;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, flush;
  logic [31:0] inst;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32)) if32 ();
  imm_gen_pipe_if #(.XLEN(64)) if64 ();

  assign if32.in_valid = in_valid;
  assign if32.inst = inst;
  assign if32.out_ready = out_ready;
  assign if32.flush = flush;
  assign if64.in_valid = in_valid;
  assign if64.inst = inst;
  assign if64.out_ready = out_ready;
  assign if64.flush = flush;

`ifdef IMM_GEN_PIPE_STATS_EN
  logic [31:0] sd32, sd64;
  logic [15:0] se32, se64;
  imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32),
                                                   .stat_decoded(sd32), .stat_err(se32));
  imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64),
                                                   .stat_decoded(sd64), .stat_err(se64));
`else
  imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
  imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] imm;
    int          fmt;
    bit          err;
  } exp_t;

  exp_t mq[$];
  int   st_dec = 0;
  int   st_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode built from field arithmetic on the sign-extended word.
  function automatic exp_t model_dec(input logic [31:0] w);
    exp_t        e;
    logic [63:0] s;
    s = 64'($signed(w));
    e.imm = 64'd0;
    e.fmt = 0;
    e.err = 1'b0;
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h1B: begin
        e.imm = 64'($signed(s) >>> 20); e.fmt = 1;
      end
      7'h23: begin
        e.imm = (64'($signed(s) >>> 20) & ~64'h1F) | 64'(w[11:7]); e.fmt = 2;
      end
      7'h63: begin
        e.imm = (64'($signed(s) >>> 19) & ~64'hFFF) | (64'(w[7]) << 11)
              | (64'(w[30:25]) << 5) | (64'(w[11:8]) << 1);
        e.fmt = 3;
      end
      7'h6F: begin
        e.imm = (64'($signed(s) >>> 11) & ~64'hFFFFF) | 64'(w & 32'h000FF000)
              | (64'(w[20]) << 11) | (64'(w[30:21]) << 1);
        e.fmt = 5;
      end
      7'h37, 7'h17: begin
        e.imm = s & ~64'hFFF; e.fmt = 4;
      end
      7'h73: if (w[14]) begin
        e.imm = 64'(w[19:15]); e.fmt = 6;
      end
      7'h33, 7'h0F: ;
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      automatic bit push = in_valid && (mq.size() < DEPTH);
      automatic bit pop  = out_ready && (mq.size() > 0);
      if (flush) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (push) begin
          automatic exp_t e = model_dec(inst);
          mq.push_back(e);
          st_dec++;
          if (e.err && st_err < 65535) st_err++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready32", 64'(if32.in_ready), 64'(mq.size() < DEPTH));
      chk("in_ready64", 64'(if64.in_ready), 64'(mq.size() < DEPTH));
      chk("out_valid32", 64'(if32.out_valid), 64'(mq.size() > 0));
      chk("out_valid64", 64'(if64.out_valid), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("imm32", 64'(if32.imm), 64'(mq[0].imm[31:0]));
        chk("imm64", if64.imm, mq[0].imm);
        chk("fmt32", 64'(if32.imm_fmt), 64'(mq[0].fmt));
        chk("fmt64", 64'(if64.imm_fmt), 64'(mq[0].fmt));
        chk("err32", 64'(if32.imm_err), 64'(mq[0].err));
        chk("err64", 64'(if64.imm_err), 64'(mq[0].err));
      end
`ifdef IMM_GEN_PIPE_STATS_EN
      chk("stat_decoded32", 64'(sd32), 64'(st_dec));
      chk("stat_decoded64", 64'(sd64), 64'(st_dec));
      chk("stat_err32", 64'(se32), 64'(st_err));
      chk("stat_err64", 64'(se64), 64'(st_err));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vec4 [4] = '{32'hFE112E23, 32'hFE0008E3, 32'h0002D073, 32'h002081B3};
  logic [31:0] mix [12] = '{32'h00A00093, 32'h80000037, 32'h00112623, 32'h00208463,
                            32'h7FFFF06F, 32'h00000073, 32'h0000000F, 32'h0000007F,
                            32'hFFF2B503, 32'h0FFFF017, 32'hFFF7D0F3, 32'h8000811B};

  initial begin
    exp_t p;
    rst_n = 1'b0; in_valid = 1'b0; inst = '0; out_ready = 1'b0; flush = 1'b0;

    // Pin the reference model with hand-decoded words.
    p = model_dec(32'hFFF00093);
    chk("pin_addi_imm", p.imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pin_addi_fmt", 64'(p.fmt), 64'd1);
    p = model_dec(32'h800000B7);
    chk("pin_lui_imm", p.imm, 64'hFFFF_FFFF_8000_0000);
    p = model_dec(32'h8000006F);
    chk("pin_jal_imm", p.imm, 64'hFFFF_FFFF_FFF0_0000);
    p = model_dec(32'hFE112E23);
    chk("pin_sw_imm", p.imm, 64'hFFFF_FFFF_FFFF_FFFC);
    p = model_dec(32'h0002D073);
    chk("pin_csrwi_imm", p.imm, 64'd5);
    chk("pin_csrwi_fmt", 64'(p.fmt), 64'd6);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(if32.out_valid), 64'd0);
    chk("rst_imm64", if64.imm, 64'd0);
    chk("rst_fmt", 64'(if64.imm_fmt), 64'd0);
    chk("rst_err", 64'(if32.imm_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("idle_in_ready", 64'(if32.in_ready), 64'd1);
    chk("idle_imm32", 64'(if32.imm), 64'd0);

    // addi x1,x0,-1 appears the cycle after acceptance
    inst = 32'hFFF00093; in_valid = 1'b1; step(); in_valid = 1'b0;
    chk("t2_valid", 64'(if32.out_valid), 64'd1);
    chk("t2_imm32", 64'(if32.imm), 64'hFFFF_FFFF);
    chk("t2_fmt", 64'(if32.imm_fmt), 64'd1);
    out_ready = 1'b1; step();

    // lui / jal on the 64-bit instance
    out_ready = 1'b0; inst = 32'h800000B7; in_valid = 1'b1; step();
    chk("t3_lui64", if64.imm, 64'hFFFF_FFFF_8000_0000);
    chk("t3_lui_fmt", 64'(if64.imm_fmt), 64'd4);
    out_ready = 1'b1; inst = 32'h8000006F; step(); in_valid = 1'b0;
    chk("t3_jal64", if64.imm, 64'hFFFF_FFFF_FFF0_0000);
    chk("t3_jal_fmt", 64'(if64.imm_fmt), 64'd5);
    step();

    // fill, hold, offer a fifth word while full, then drain
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      inst = vec4[i]; in_valid = 1'b1; step();
    end
    in_valid = 1'b0;
    chk("t4_full_in_ready", 64'(if32.in_ready), 64'd0);
    inst = 32'h00100093; in_valid = 1'b1; out_ready = 1'b1; step(); in_valid = 1'b0;
    chk("t4_after_pop_in_ready", 64'(if32.in_ready), 64'd1);
    repeat (4) step();

    // flush with a push in the same cycle
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inst = mix[i]; in_valid = 1'b1; step();
    end
    inst = 32'h00100093; flush = 1'b1; step(); flush = 1'b0; in_valid = 1'b0;
    chk("t5_flush_valid", 64'(if32.out_valid), 64'd0);
    step();
    chk("t5_flush_stays_empty", 64'(if64.out_valid), 64'd0);

    // unrecognised opcode
    inst = 32'h0000007F; in_valid = 1'b1; step(); in_valid = 1'b0;
    chk("t6_err", 64'(if32.imm_err), 64'd1);
    chk("t6_fmt", 64'(if32.imm_fmt), 64'd0);
    chk("t6_imm", if64.imm, 64'd0);
`ifdef IMM_GEN_PIPE_STATS_EN
    chk("t6_stat_err", 64'(se32), 64'd1);
    chk("t6_stat_decoded", 64'(sd64), 64'd11);
`endif
    out_ready = 1'b1; step();

    // mixed traffic with stalls and one mid-stream flush
    for (int i = 0; i < 40; i++) begin
      in_valid  = (i % 5) != 4;
      inst      = mix[i % 12];
      out_ready = (i % 3) != 0;
      flush     = (i == 27);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
